scan_chain_engine: RTL and testbench

//  Parametrised scan-chain master and successor to the fixed-length UART scan writer.

---
 rtl/scan_chain_engine_pkg.sv | 25 ++
 rtl/scan_chain_engine_clk_gen.sv | 43 ++++
 rtl/scan_chain_engine.sv | 177 +++++++++++++++++
 tb/tb_scan_chain_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_engine_pkg.sv
// Shared constants for the scan-chain master: opcodes, response status codes
// and the FSM state encoding.
package scan_chain_engine_pkg;

    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_RESET    = 2'b01;
    localparam logic [1:0] OP_WRITE_RB = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_RST    = 2'b01;
    localparam logic [1:0] ST_BADLEN = 2'b10;
    localparam logic [1:0] ST_BADOP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RST_PULSE,
        S_SHIFT_ADDR,
        S_SHIFT_DATA,
        S_UPDATE,
        S_RESPOND
    } state_t;

endpackage

// File: rtl/scan_chain_engine_clk_gen.sv
// scan_clk_gen: divides clk into scan bit periods of 2*HALF clk.
// Each bit: scan_clk low for HALF clk, then high for HALF clk.
//   clk       system clock
//   rst_n     async active-low reset (already synchronised)
//   en        run; phase counter and scan_clk are held at 0 while low
//   rise_tick high in the cycle whose closing edge raises scan_clk
//   fall_tick high in the cycle whose closing edge drops scan_clk (bit end)
//   scan_clk  registered scan clock
module scan_clk_gen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick,
    output logic scan_clk
);

    localparam int PW = (2 * HALF > 2) ? $clog2(2 * HALF) : 1;
    localparam logic [PW-1:0] RISE_PH = PW'(HALF - 1);
    localparam logic [PW-1:0] LAST_PH = PW'(2 * HALF - 1);

    logic [PW-1:0] phase;

    assign rise_tick = en && (phase == RISE_PH);
    assign fall_tick = en && (phase == LAST_PH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            scan_clk <= 1'b0;
        end else if (!en) begin
            phase    <= '0;
            scan_clk <= 1'b0;
        end else begin
            phase <= fall_tick ? '0 : phase + PW'(1);
            if (rise_tick)      scan_clk <= 1'b1;
            else if (fall_tick) scan_clk <= 1'b0;
        end
    end

endmodule

// File: rtl/scan_chain_engine.sv
// scan_chain_engine: scan-chain master. Accepts one command per handshake
// (write, chain reset, write+readback), shifts an address+payload frame into
// the chain, optionally captures scan_out during the payload and returns a
// status/data response.
//   clk, reset                system clock, async active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only when idle)
//   cmd_op/addr/len/payload   command fields, registered on accept
//   rsp_valid/rsp_ready       response handshake
//   rsp_status/rsp_data       status code and captured payload bits
//   busy                      accept .. response handshake
//   scan_clk/en/in/reset      chain drive pins; scan_out chain return
module scan_chain_engine
    import scan_chain_engine_pkg::*;
#(
    parameter int CLOCK_FREQ    = 100_000_000,
    parameter int SCAN_CLK_FREQ = 1_000_000,
    parameter int ADDR_BITS     = 12,
    parameter int PAYLOAD_BITS  = 169,
    parameter int LEN_BITS      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_BITS-1:0]    cmd_addr,
    input  logic [LEN_BITS-1:0]     cmd_len,
    input  logic [PAYLOAD_BITS-1:0] cmd_payload,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_status,
    output logic [PAYLOAD_BITS-1:0] rsp_data,
    output logic                    busy,
    output logic                    scan_clk,
    output logic                    scan_en,
    output logic                    scan_in,
    output logic                    scan_reset,
    input  logic                    scan_out
);

    localparam int HALF       = CLOCK_FREQ / (2 * SCAN_CLK_FREQ);
    localparam int FRAME_BITS = ADDR_BITS + PAYLOAD_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int WAIT_W     = $clog2(2 * HALF + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(2 * HALF - 1);

    if (HALF < 1) begin : g_bad_half
        $error("scan_chain_engine: CLOCK_FREQ/(2*SCAN_CLK_FREQ) must be >= 1");
    end
    if ((1 << LEN_BITS) <= PAYLOAD_BITS) begin : g_bad_len
        $error("scan_chain_engine: LEN_BITS too narrow for PAYLOAD_BITS");
    end

    // Async assert, sync release.
    logic [1:0] rst_sync;
    logic       rst_n;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t                  state, state_n;
    logic [1:0]              op_r;
    logic [LEN_BITS-1:0]     len_r;
    logic [FRAME_BITS-1:0]   frame_r;
    logic [PAYLOAD_BITS-1:0] cap_r;
    logic [1:0]              status_r;
    logic [CNT_W-1:0]        bit_cnt;
    logic [WAIT_W-1:0]       wait_cnt;
    logic                    scan_in_r;

    logic                    cmd_fire, rise_tick, fall_tick, len_bad;
    logic [LEN_BITS-1:0]     len_eff;
    logic [CNT_W-1:0]        last_bit;
    logic [PAYLOAD_BITS-1:0] cap_top;

    assign cmd_ready = (state == S_IDLE) && rst_n;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign len_eff   = (cmd_len == '0) ? LEN_BITS'(PAYLOAD_BITS) : cmd_len;
    assign len_bad   = (len_r > LEN_BITS'(PAYLOAD_BITS));
    // Frame index of the final payload bit; only used once len_r is known legal.
    assign last_bit  = CNT_W'(ADDR_BITS) + CNT_W'(len_r) - CNT_W'(1);
    // Readback samples enter at bit len-1 and walk toward bit 0.
    assign cap_top   = PAYLOAD_BITS'(1) << (len_r - LEN_BITS'(1));

    assign busy       = (state != S_IDLE);
    assign rsp_valid  = (state == S_RESPOND);
    assign rsp_status = status_r;
    assign rsp_data   = cap_r;
    assign scan_en    = (state == S_SHIFT_ADDR) || (state == S_SHIFT_DATA);
    assign scan_reset = (state == S_RST_PULSE);
    assign scan_in    = scan_in_r;

    scan_clk_gen #(.HALF(HALF)) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (scan_en),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .scan_clk  (scan_clk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:       if (cmd_fire) state_n = S_CHECK;
            S_CHECK: begin
                if (op_r == OP_RSVD || len_bad) state_n = S_RESPOND;
                else if (op_r == OP_RESET)      state_n = S_RST_PULSE;
                else                            state_n = S_SHIFT_ADDR;
            end
            S_RST_PULSE:  if (wait_cnt == WAIT_LAST) state_n = S_RESPOND;
            S_SHIFT_ADDR: if (fall_tick && bit_cnt == CNT_W'(ADDR_BITS - 1)) state_n = S_SHIFT_DATA;
            S_SHIFT_DATA: if (fall_tick && bit_cnt == last_bit) state_n = S_UPDATE;
            S_UPDATE:     if (wait_cnt == WAIT_LAST) state_n = S_RESPOND;
            S_RESPOND:    if (rsp_ready) state_n = S_IDLE;
            default:      state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= OP_WRITE;
            len_r     <= '0;
            frame_r   <= '0;
            cap_r     <= '0;
            status_r  <= ST_OK;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            scan_in_r <= 1'b0;
        end else begin
            wait_cnt <= ((state == S_RST_PULSE || state == S_UPDATE) && state_n == state)
                        ? wait_cnt + WAIT_W'(1) : '0;
            case (state)
                S_IDLE: if (cmd_fire) begin
                    op_r     <= cmd_op;
                    len_r    <= len_eff;
                    frame_r  <= {cmd_payload, cmd_addr};
                    cap_r    <= '0;
                    status_r <= ST_OK;
                    bit_cnt  <= '0;
                end
                S_CHECK: begin
                    if (op_r == OP_RSVD)       status_r <= ST_BADOP;
                    else if (len_bad)          status_r <= ST_BADLEN;
                    else if (op_r == OP_RESET) status_r <= ST_RST;
                    // Entering the shift is the falling edge of bit 0.
                    if (state_n == S_SHIFT_ADDR) begin
                        scan_in_r <= frame_r[0];
                        frame_r   <= frame_r >> 1;
                    end
                end
                S_SHIFT_ADDR, S_SHIFT_DATA: begin
                    if (rise_tick && state == S_SHIFT_DATA && op_r == OP_WRITE_RB)
                        cap_r <= (cap_r >> 1) | (scan_out ? cap_top : '0);
                    if (fall_tick) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (state_n == S_UPDATE) begin
                            scan_in_r <= 1'b0;
                        end else begin
                            scan_in_r <= frame_r[0];
                            frame_r   <= frame_r >> 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_engine.sv
module tb_scan_chain_engine;

    localparam int A = 12;
    localparam int P = 169;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = '0;
    logic [A-1:0] cmd_addr = '0;
    logic [7:0]   cmd_len = '0;
    logic [P-1:0] cmd_payload = '0;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_status;
    logic [P-1:0] rsp_data;
    logic         busy, scan_clk, scan_en, scan_in, scan_reset;
    logic         scan_out;

    scan_chain_engine #(
        .CLOCK_FREQ(20), .SCAN_CLK_FREQ(4), .ADDR_BITS(A), .PAYLOAD_BITS(P), .LEN_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_payload(cmd_payload),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_data(rsp_data), .busy(busy), .scan_clk(scan_clk), .scan_en(scan_en),
        .scan_in(scan_in), .scan_reset(scan_reset), .scan_out(scan_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] st; logic [P-1:0] data; } rsp_t;
    rsp_t         sb_q[$];
    logic [P-1:0] ref_chain [int];   // reference: what each chain should hold
    logic [P-1:0] chain_m [int];     // chain model driven from the scan pins
    int total = 0, bad = 0;
    int en_cyc = 0, srst_cyc = 0, rise_cnt = 0;
    int en0, sr0, r0;
    int rdy_mode = 0;                // 0 random, 1 always ready, 2 never ready

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [P-1:0] msk(input int n);
        logic [P-1:0] m = '0;
        for (int i = 0; i < n && i < P; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [P-1:0] rnd_pl();
        logic [191:0] t;
        for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
        return t[P-1:0];
    endfunction

    function automatic logic [P-1:0] get_ref(input int a);
        return ref_chain.exists(a) ? ref_chain[a] : '0;
    endfunction

    function automatic logic [P-1:0] get_m(input int a);
        return chain_m.exists(a) ? chain_m[a] : '0;
    endfunction

    // Chain model: first A bits select the chain, the rest are its new contents.
    // Old contents stream out on scan_out while the new ones stream in.
    initial begin
        int n;
        logic [A-1:0] maddr;
        logic [P-1:0] mdata;
        n = 0; maddr = '0; mdata = '0; scan_out = 1'b0;
        forever begin
            @(posedge scan_clk or negedge scan_en or posedge scan_reset);
            if (scan_reset === 1'b1) begin
                chain_m.delete();
            end else if (scan_en !== 1'b1) begin
                if (reset === 1'b1 && n >= A) chain_m[int'(maddr)] = mdata;
                n = 0; maddr = '0; mdata = '0; scan_out = 1'b0;
            end else if (scan_clk === 1'b1) begin
                if (n < A) maddr[n] = scan_in;
                else if (n - A < P) mdata[n - A] = scan_in;
                n++;
                if (n >= A && n - A < P) scan_out = get_m(int'(maddr))[n - A];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (scan_en === 1'b1) en_cyc++;
        if (scan_reset === 1'b1) srst_cyc++;
    end

    initial forever begin
        @(posedge scan_clk);
        rise_cnt++;
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor.
    initial forever begin
        @(negedge clk);
        if (reset === 1'b1 && rsp_valid === 1'b1) begin
            if (rsp_ready !== 1'b1) begin
                chk("stall_pins_idle", {scan_en, scan_clk, scan_reset, busy}, 4'b0001);
            end else if (sb_q.size() == 0) begin
                chk("unexpected_rsp", {rsp_status, rsp_data}, '0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                chk("rsp_status", rsp_status, e.st);
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    task automatic send(input logic [1:0] op, input int addr, input int len,
                        input logic [P-1:0] pl, input bit push);
        int   n, t;
        rsp_t e;
        n = (len == 0) ? P : len;
        if (push) begin
            e.data = '0;
            if (op == 2'b11) e.st = 2'b11;
            else if (n > P) e.st = 2'b10;
            else if (op == 2'b01) begin
                e.st = 2'b01;
                ref_chain.delete();
            end else begin
                e.st = 2'b00;
                if (op == 2'b10) e.data = get_ref(addr) & msk(n);
                ref_chain[addr] = pl & msk(n);
            end
            sb_q.push_back(e);
        end
        t = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        en0 = en_cyc; sr0 = srst_cyc; r0 = rise_cnt;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = A'(addr); cmd_len = 8'(len); cmd_payload = pl;
        @(negedge clk);
        chk("accepted_busy", {cmd_ready, busy}, 2'b01);
        // Junk on the command bus must be ignored while busy.
        cmd_op = 2'($urandom); cmd_addr = A'($urandom); cmd_len = 8'($urandom); cmd_payload = rnd_pl();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input logic [1:0] op, input int addr, input int len);
        int n, t, er, ee, es;
        n = (len == 0) ? P : len;
        t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_seen", sb_q.size(), 0);
        er = 0; ee = 0; es = 0;
        if (op == 2'b01 && n <= P) es = 4;
        else if (op != 2'b11 && n <= P) begin
            er = A + n;
            ee = (A + n) * 4;
        end
        chk("scan_clk_rises", rise_cnt - r0, er);
        chk("scan_en_cycles", en_cyc - en0, ee);
        chk("scan_reset_cycles", srst_cyc - sr0, es);
        if ((op == 2'b00 || op == 2'b10) && n <= P)
            chk("chain_contents", get_m(addr), get_ref(addr));
    endtask

    initial begin
        logic [P-1:0] pa, pb;
        int t;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_ctrl", {cmd_ready, busy, rsp_valid, rsp_status}, 5'b0);
        chk("reset_pins", {scan_en, scan_clk, scan_in, scan_reset}, 4'b0);
        chk("reset_data", rsp_data, '0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1'b1);

        // Full-length write and a 53-bit write.
        send(2'b00, 2, 0, rnd_pl(), 1'b1);  finish_cmd(2'b00, 2, 0);
        send(2'b00, 1, 53, rnd_pl(), 1'b1); finish_cmd(2'b00, 1, 53);

        // Reset in the middle of a shift: nothing lands, no response.
        send(2'b00, 2, 0, rnd_pl(), 1'b0);
        t = 0;
        while (rise_cnt - r0 < 37 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        reset = 1'b0;
        #1;
        chk("abort_outputs", {scan_en, scan_clk, rsp_valid, cmd_ready, busy}, 5'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("ready_after_abort", cmd_ready, 1'b1);
        chk("chain_not_updated", get_m(2), get_ref(2));
        send(2'b00, 2, 30, rnd_pl(), 1'b1); finish_cmd(2'b00, 2, 30);

        // Chain reset pulse.
        send(2'b01, 0, 5, rnd_pl(), 1'b1); finish_cmd(2'b01, 0, 5);

        // Rejected commands turn around quickly with no pin activity.
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        send(2'b00, 5, 200, rnd_pl(), 1'b1);
        @(negedge clk);
        chk("badlen_ready_3clk", cmd_ready, 1'b1);
        finish_cmd(2'b00, 5, 200);
        send(2'b11, 5, 10, rnd_pl(), 1'b1);
        @(negedge clk);
        chk("badop_ready_3clk", cmd_ready, 1'b1);
        finish_cmd(2'b11, 5, 10);

        // Readback returns the previous contents; chain then holds the new value.
        rdy_mode = 0;
        pa = rnd_pl(); pb = rnd_pl();
        send(2'b00, 3, 20, pa, 1'b1); finish_cmd(2'b00, 3, 20);
        send(2'b10, 3, 20, pb, 1'b1); finish_cmd(2'b10, 3, 20);

        // Response stall.
        rdy_mode = 2;
        repeat (2) @(negedge clk);
        send(2'b10, 1, 7, rnd_pl(), 1'b1);
        t = 0;
        while (rsp_valid !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (40) @(negedge clk);
        chk("stall_holds_rsp", {rsp_valid, cmd_ready}, 2'b10);
        rdy_mode = 0;
        finish_cmd(2'b10, 1, 7);

        // Random mix.
        for (int i = 0; i < 12; i++) begin
            int r, a, l;
            logic [1:0] op;
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 3);
            l = $urandom_range(0, 40);
            op = (r < 4) ? 2'b00 : (r < 7) ? 2'b10 : (r == 7) ? 2'b01 : (r == 8) ? 2'b11 : 2'b00;
            if (r == 9) l = $urandom_range(170, 255);
            send(op, a, l, rnd_pl(), 1'b1);
            finish_cmd(op, a, l);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
